// File: rtl/tdm_demux_pkg.sv
// ============================================================================
// tdm_demux_pkg : shared types and constants for the eight-slot TDM demux
// Revision      : 1.0
// ============================================================================
`default_nettype none

package tdm_demux_pkg;

  localparam int SLOTS = 8;

  typedef logic [2:0] slot_t;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage : tdm_demux_pkg

`default_nettype wire

// File: rtl/tdm_demux8_if.sv
// ============================================================================
// tdm_demux8_if : slot-beat input and recovered-frame output bundle
//                 (Chan_Enable present only with TDM_DEMUX_CHAN_MASK_EN)
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface tdm_demux8_if
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0]       In_Data;
  logic                   In_Valid;
  logic                   Frame_Sync;
`ifdef TDM_DEMUX_CHAN_MASK_EN
  logic [SLOTS-1:0]       Chan_Enable;
`endif
  logic [SLOTS*WIDTH-1:0] Out_Data;
  logic                   Out_Valid;
  logic                   Locked;
  logic                   Sync_Error;

  modport master (
    output In_Data, In_Valid, Frame_Sync,
`ifdef TDM_DEMUX_CHAN_MASK_EN
    output Chan_Enable,
`endif
    input  Out_Data, Out_Valid, Locked, Sync_Error
  );

  modport slave (
    input  In_Data, In_Valid, Frame_Sync,
`ifdef TDM_DEMUX_CHAN_MASK_EN
    input  Chan_Enable,
`endif
    output Out_Data, Out_Valid, Locked, Sync_Error
  );

endinterface : tdm_demux8_if

`default_nettype wire

// File: rtl/tdm_slot_counter.sv
// ============================================================================
// tdm_slot_counter : wrapping 0..7 slot position with clear / load-to-one
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tdm_slot_counter
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  load_one,
  input  logic  advance,
  output slot_t slot,
  output logic  last_slot
);

  // A sync beat is itself slot 0, so the next beat lands in slot 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= slot_t'(1);
    end else if (advance) begin
      slot <= slot + slot_t'(1);
    end
  end

  assign last_slot = (slot == slot_t'(SLOTS - 1));

endmodule : tdm_slot_counter

`default_nettype wire

// File: rtl/tdm_demux8.sv
// ============================================================================
// tdm_demux8 : eight-slot TDM demultiplexer with sync hunting and flywheel
//              lock supervision; optional per-slot update mask via
//              TDM_DEMUX_CHAN_MASK_EN
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tdm_demux8
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int MISS_LIMIT = 2
)(
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux8_if.slave  bus
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  typedef logic [MISS_W-1:0] miss_t;

  state_t                         state;
  miss_t                          miss;
  logic [SLOTS-2:0][WIDTH-1:0]    shadow;
  logic [SLOTS*WIDTH-1:0]         out_data;
  logic                           out_valid;
  logic                           sync_error;

  slot_t                          slot;
  logic                           last_slot;

  logic                           beat;
  logic                           sync;
  miss_t                          miss_inc;
  logic                           miss_hit;
  logic                           flywheel;
  logic                           drop;
  logic                           cnt_clear;
  logic                           cnt_load;
  logic                           cnt_adv;
  logic [SLOTS-1:0]               chan_en;
  logic [SLOTS*WIDTH-1:0]         slot_mask;
  logic [SLOTS*WIDTH-1:0]         new_frame;
  logic [SLOTS*WIDTH-1:0]         merged;

  always_comb begin
    beat      = bus.In_Valid;
    sync      = bus.Frame_Sync;
    miss_inc  = miss + miss_t'(1);
    miss_hit  = (miss_inc == miss_t'(MISS_LIMIT));
    flywheel  = beat && (state == LOCKED) && (slot == '0) && !sync;
    drop      = flywheel && miss_hit;
    cnt_clear = drop;
    cnt_load  = beat && sync;
    cnt_adv   = beat && (state == LOCKED) && !sync && !drop;
  end

`ifdef TDM_DEMUX_CHAN_MASK_EN
  assign chan_en = bus.Chan_Enable;
`else
  assign chan_en = {SLOTS{1'b1}};
`endif

  generate
    for (genvar k = 0; k < SLOTS; k++) begin : g_mask
      assign slot_mask[k*WIDTH +: WIDTH] = {WIDTH{chan_en[k]}};
    end
  endgenerate

  assign new_frame = {bus.In_Data, shadow};
  assign merged    = (out_data & ~slot_mask) | (new_frame & slot_mask);

  tdm_slot_counter u_slot_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .load_one  (cnt_load),
    .advance   (cnt_adv),
    .slot      (slot),
    .last_slot (last_slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      miss       <= '0;
      shadow     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      sync_error <= 1'b0;
      if (beat) begin
        case (state)
          HUNT: begin
            if (sync) begin
              shadow[0] <= bus.In_Data;
              miss      <= '0;
              state     <= LOCKED;
            end
          end
          LOCKED: begin
            if (sync) begin
              // Misaligned sync restarts the frame and abandons the partial one.
              shadow[0] <= bus.In_Data;
              if (slot == '0) begin
                miss <= '0;
              end else begin
                sync_error <= 1'b1;
              end
            end else if (slot == '0) begin
              if (miss_hit) begin
                state      <= HUNT;
                miss       <= '0;
                sync_error <= 1'b1;
              end else begin
                miss      <= miss_inc;
                shadow[0] <= bus.In_Data;
              end
            end else if (last_slot) begin
              out_data  <= merged;
              out_valid <= 1'b1;
            end else begin
              shadow[slot] <= bus.In_Data;
            end
          end
        endcase
      end
    end
  end

  assign bus.Out_Data   = out_data;
  assign bus.Out_Valid  = out_valid;
  assign bus.Locked     = (state == LOCKED);
  assign bus.Sync_Error = sync_error;

endmodule : tdm_demux8

`default_nettype wire
